// File: rtl/register_file.sv
// Architectural register file with per-register rename tags (0 = value valid).
// Combinational read ports with commit bypass; commit, rename and misbranch flush update on posedge.
module register_file #(
  parameter int REG_NUM      = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic [$clog2(REG_NUM)-1:0]   rs1_from_dispatcher,
  input  logic [$clog2(REG_NUM)-1:0]   rs2_from_dispatcher,
  output logic [ROB_ID_WIDTH-1:0]      Q1_to_dispatcher,
  output logic [ROB_ID_WIDTH-1:0]      Q2_to_dispatcher,
  output logic [DATA_WIDTH-1:0]        V1_to_dispatcher,
  output logic [DATA_WIDTH-1:0]        V2_to_dispatcher,
  input  logic                         rename_signal_from_dispatcher,
  input  logic [$clog2(REG_NUM)-1:0]   rd_from_dispatcher,
  input  logic [ROB_ID_WIDTH-1:0]      rob_id_from_dispatcher,
  input  logic                         commit_flag_from_rob,
  input  logic [$clog2(REG_NUM)-1:0]   rd_from_rob,
  input  logic [ROB_ID_WIDTH-1:0]      Q_from_rob,
  input  logic [DATA_WIDTH-1:0]        V_from_rob,
  input  logic                         misbranch_flag_from_rob
);
  localparam int IDX_W = $clog2(REG_NUM);

  logic [DATA_WIDTH-1:0]   r_val [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] r_tag [REG_NUM];

  logic w_commit_en;
  logic w_rename_en;
  logic w_hit1;
  logic w_hit2;

  assign w_commit_en = commit_flag_from_rob && (rd_from_rob != '0);
  assign w_rename_en = rename_signal_from_dispatcher && (rd_from_dispatcher != '0)
                       && !misbranch_flag_from_rob;

  // A commit retiring the register's current producer is forwarded straight to the reader.
  assign w_hit1 = commit_flag_from_rob && (rd_from_rob == rs1_from_dispatcher)
                  && (Q_from_rob == r_tag[rs1_from_dispatcher]);
  assign w_hit2 = commit_flag_from_rob && (rd_from_rob == rs2_from_dispatcher)
                  && (Q_from_rob == r_tag[rs2_from_dispatcher]);

  always_comb begin
    Q1_to_dispatcher = '0;
    V1_to_dispatcher = '0;
    if (rs1_from_dispatcher != '0) begin
      if (misbranch_flag_from_rob) begin
        V1_to_dispatcher = r_val[rs1_from_dispatcher];
      end else if (w_hit1) begin
        V1_to_dispatcher = V_from_rob;
      end else begin
        Q1_to_dispatcher = r_tag[rs1_from_dispatcher];
        V1_to_dispatcher = r_val[rs1_from_dispatcher];
      end
    end
  end

  always_comb begin
    Q2_to_dispatcher = '0;
    V2_to_dispatcher = '0;
    if (rs2_from_dispatcher != '0) begin
      if (misbranch_flag_from_rob) begin
        V2_to_dispatcher = r_val[rs2_from_dispatcher];
      end else if (w_hit2) begin
        V2_to_dispatcher = V_from_rob;
      end else begin
        Q2_to_dispatcher = r_tag[rs2_from_dispatcher];
        V2_to_dispatcher = r_val[rs2_from_dispatcher];
      end
    end
  end

  // Tag priority: flush, then rename, then a matching commit clear. x0 is never updated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (rdy) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (misbranch_flag_from_rob) begin
          r_tag[i] <= '0;
        end else if (w_rename_en && (rd_from_dispatcher == IDX_W'(i))) begin
          r_tag[i] <= rob_id_from_dispatcher;
        end else if (w_commit_en && (rd_from_rob == IDX_W'(i)) && (r_tag[i] == Q_from_rob)) begin
          r_tag[i] <= '0;
        end
      end
      if (w_commit_en) begin
        r_val[rd_from_rob] <= V_from_rob;
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios plus randomized traffic checked against
// an array-based reference of the architectural registers and their rename tags.
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [4:0]  rs1_from_dispatcher;
  logic [4:0]  rs2_from_dispatcher;
  logic [4:0]  Q1_to_dispatcher;
  logic [4:0]  Q2_to_dispatcher;
  logic [31:0] V1_to_dispatcher;
  logic [31:0] V2_to_dispatcher;
  logic        rename_signal_from_dispatcher;
  logic [4:0]  rd_from_dispatcher;
  logic [4:0]  rob_id_from_dispatcher;
  logic        commit_flag_from_rob;
  logic [4:0]  rd_from_rob;
  logic [4:0]  Q_from_rob;
  logic [31:0] V_from_rob;
  logic        misbranch_flag_from_rob;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_val [32];
  logic [4:0]  m_tag [32];
  bit          m_known = 1'b0;

  register_file #(.REG_NUM(32), .DATA_WIDTH(32), .ROB_ID_WIDTH(5)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .rdy                           (rdy),
    .rs1_from_dispatcher           (rs1_from_dispatcher),
    .rs2_from_dispatcher           (rs2_from_dispatcher),
    .Q1_to_dispatcher              (Q1_to_dispatcher),
    .Q2_to_dispatcher              (Q2_to_dispatcher),
    .V1_to_dispatcher              (V1_to_dispatcher),
    .V2_to_dispatcher              (V2_to_dispatcher),
    .rename_signal_from_dispatcher (rename_signal_from_dispatcher),
    .rd_from_dispatcher            (rd_from_dispatcher),
    .rob_id_from_dispatcher        (rob_id_from_dispatcher),
    .commit_flag_from_rob          (commit_flag_from_rob),
    .rd_from_rob                   (rd_from_rob),
    .Q_from_rob                    (Q_from_rob),
    .V_from_rob                    (V_from_rob),
    .misbranch_flag_from_rob       (misbranch_flag_from_rob)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference read: what the dispatcher should see for source s right now.
  function automatic logic [4:0] ref_q(input logic [4:0] s);
    if (s == 0) return 5'd0;
    if (misbranch_flag_from_rob) return 5'd0;
    if (commit_flag_from_rob && rd_from_rob == s && Q_from_rob == m_tag[s]) return 5'd0;
    return m_tag[s];
  endfunction

  function automatic logic [31:0] ref_v(input logic [4:0] s);
    if (s == 0) return 32'd0;
    if (misbranch_flag_from_rob) return m_val[s];
    if (commit_flag_from_rob && rd_from_rob == s && Q_from_rob == m_tag[s]) return V_from_rob;
    return m_val[s];
  endfunction

  // Reference state update for one clock edge, from the inputs currently applied.
  task automatic ref_update();
    logic [4:0] old_tag [32];
    if (!rst) begin
      for (int r = 0; r < 32; r++) begin m_val[r] = 0; m_tag[r] = 0; end
      m_known = 1'b1;
      return;
    end
    if (!rdy) return;
    old_tag = m_tag;
    if (misbranch_flag_from_rob) begin
      for (int r = 0; r < 32; r++) m_tag[r] = 0;
    end else begin
      if (commit_flag_from_rob && rd_from_rob != 0 && old_tag[rd_from_rob] == Q_from_rob)
        m_tag[rd_from_rob] = 0;
      if (rename_signal_from_dispatcher && rd_from_dispatcher != 0)
        m_tag[rd_from_dispatcher] = rob_id_from_dispatcher;
    end
    if (commit_flag_from_rob && rd_from_rob != 0) m_val[rd_from_rob] = V_from_rob;
  endtask

  // Inputs are applied just after a negedge; reads are checked, then the edge is taken.
  task automatic cycle();
    #1;
    if (m_known) begin
      check("Q1", 32'(Q1_to_dispatcher), 32'(ref_q(rs1_from_dispatcher)));
      check("V1", V1_to_dispatcher, ref_v(rs1_from_dispatcher));
      check("Q2", 32'(Q2_to_dispatcher), 32'(ref_q(rs2_from_dispatcher)));
      check("V2", V2_to_dispatcher, ref_v(rs2_from_dispatcher));
    end
    @(posedge clk);
    ref_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1; rdy = 1;
    rename_signal_from_dispatcher = 0; rd_from_dispatcher = 0; rob_id_from_dispatcher = 0;
    commit_flag_from_rob = 0; rd_from_rob = 0; Q_from_rob = 0; V_from_rob = 0;
    misbranch_flag_from_rob = 0;
  endtask

  task automatic do_rename(input logic [4:0] rd, input logic [4:0] id);
    idle();
    rename_signal_from_dispatcher = 1; rd_from_dispatcher = rd; rob_id_from_dispatcher = id;
    cycle();
  endtask

  task automatic probe(input string tag, input logic [4:0] s, input logic [4:0] q, input logic [31:0] v);
    rs1_from_dispatcher = s;
    #1;
    check({tag, "_Q"}, 32'(Q1_to_dispatcher), 32'(q));
    check({tag, "_V"}, V1_to_dispatcher, v);
  endtask

  initial begin
    idle();
    rs1_from_dispatcher = 0; rs2_from_dispatcher = 0;
    @(negedge clk);

    // Reset
    rst = 0; cycle(); rst = 0; cycle();
    idle();
    rs1_from_dispatcher = 5; rs2_from_dispatcher = 31;
    #1;
    check("rst_Q1", 32'(Q1_to_dispatcher), 0);
    check("rst_Q2", 32'(Q2_to_dispatcher), 0);
    check("rst_V1", V1_to_dispatcher, 0);
    check("rst_V2", V2_to_dispatcher, 0);
    cycle();

    // Rename then commit bypass
    do_rename(5, 3);
    idle(); probe("ren_x5", 5, 3, 0);
    commit_flag_from_rob = 1; rd_from_rob = 5; Q_from_rob = 3; V_from_rob = 32'hDEADBEEF;
    probe("bypass_x5", 5, 0, 32'hDEADBEEF);
    cycle();
    idle(); probe("stored_x5", 5, 0, 32'hDEADBEEF);

    // Stale commit
    do_rename(7, 2);
    do_rename(7, 9);
    idle(); commit_flag_from_rob = 1; rd_from_rob = 7; Q_from_rob = 2; V_from_rob = 32'h11;
    rs1_from_dispatcher = 7; cycle();
    idle(); probe("stale_x7", 7, 9, 32'h11);
    commit_flag_from_rob = 1; rd_from_rob = 7; Q_from_rob = 9; V_from_rob = 32'h22;
    cycle();
    idle(); probe("final_x7", 7, 0, 32'h22);

    // Rename wins over commit clear on the same register
    do_rename(4, 6);
    idle(); commit_flag_from_rob = 1; rd_from_rob = 4; Q_from_rob = 6; V_from_rob = 32'h55;
    rename_signal_from_dispatcher = 1; rd_from_dispatcher = 4; rob_id_from_dispatcher = 8;
    cycle();
    idle(); probe("rencommit_x4", 4, 8, 32'h55);

    // Misbranch flush with commit write and ignored rename
    do_rename(1, 1); do_rename(2, 2); do_rename(3, 3);
    idle(); misbranch_flag_from_rob = 1;
    commit_flag_from_rob = 1; rd_from_rob = 1; Q_from_rob = 1; V_from_rob = 32'h40;
    rename_signal_from_dispatcher = 1; rd_from_dispatcher = 9; rob_id_from_dispatcher = 4;
    probe("misb_read_x2", 2, 0, 0);
    cycle();
    idle();
    probe("misb_x1", 1, 0, 32'h40);
    probe("misb_x2", 2, 0, 0);
    probe("misb_x3", 3, 0, 0);
    probe("misb_x4", 4, 0, 32'h55);
    probe("misb_x9", 9, 0, 0);

    // x0 and rdy hold
    idle(); rename_signal_from_dispatcher = 1; rd_from_dispatcher = 0; rob_id_from_dispatcher = 5;
    commit_flag_from_rob = 1; rd_from_rob = 0; Q_from_rob = 0; V_from_rob = 1;
    cycle();
    idle(); probe("x0", 0, 0, 0);
    rdy = 0; commit_flag_from_rob = 1; rd_from_rob = 3; Q_from_rob = 7; V_from_rob = 32'h99;
    rename_signal_from_dispatcher = 1; rd_from_dispatcher = 3; rob_id_from_dispatcher = 12;
    cycle();
    idle(); probe("rdy_hold_x3", 3, 0, 0);

    // Randomized traffic against the reference
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 99) != 0);
      rdy = ($urandom_range(0, 9) != 0);
      rs1_from_dispatcher = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rs2_from_dispatcher = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rename_signal_from_dispatcher = $urandom_range(0, 1);
      rd_from_dispatcher = 5'($urandom_range(0, 7));
      rob_id_from_dispatcher = 5'($urandom_range(1, 16));
      commit_flag_from_rob = $urandom_range(0, 1);
      rd_from_rob = 5'($urandom_range(0, 7));
      Q_from_rob = $urandom_range(0, 1) ? m_tag[rd_from_rob] : 5'($urandom_range(1, 16));
      V_from_rob = $urandom;
      misbranch_flag_from_rob = ($urandom_range(0, 19) == 0);
      cycle();
    end

    // Sweep every register through both read ports
    for (int r = 0; r < 32; r++) begin
      idle();
      rs1_from_dispatcher = 5'(r);
      rs2_from_dispatcher = 5'(31 - r);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
